// File: rtl/tc_pl_bus_pkg.sv
// Shared definitions for the PL bus controllers: FSM state encoding,
// default watchdog/gap constants and a constant-evaluable clog2.
package tc_pl_bus_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_TRIG = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_GAP  = 2'd3;

    localparam int DEF_TMO_CYC = 50000;
    localparam int DEF_GAP_CYC = 8;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tc_pl_bus_rr_pick.sv
// Combinational round-robin picker: first eligible channel strictly after
// i_rr_ptr, searching upward with wrap modulo CH_NUM.
module tc_pl_bus_rr_pick #(
    parameter int CH_NUM = 4,
    parameter int CH_W   = 2
) (
    input  logic [CH_NUM-1:0] i_elig,
    input  logic [CH_W-1:0]   i_rr_ptr,
    output logic              o_pick_vld,
    output logic [CH_W-1:0]   o_pick_idx,
    output logic [CH_NUM-1:0] o_pick_oh
);

    localparam int SW = CH_W + 1;

    logic [CH_W-1:0]   w_cand_idx [CH_NUM];
    logic [CH_NUM-1:0] w_cand_oh  [CH_NUM];
    logic [CH_NUM-1:0] w_cand_hit;

    // Candidate gi is the channel (gi+1) places after the pointer, reduced mod CH_NUM.
    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_cand
            logic [SW-1:0] w_sum;
            assign w_sum          = SW'(i_rr_ptr) + SW'(gi + 1);
            assign w_cand_idx[gi] = (w_sum >= SW'(CH_NUM)) ? CH_W'(w_sum - SW'(CH_NUM))
                                                           : CH_W'(w_sum);
            assign w_cand_oh[gi]  = CH_NUM'(1) << w_cand_idx[gi];
            assign w_cand_hit[gi] = |(w_cand_oh[gi] & i_elig);
        end
    endgenerate

    always_comb begin
        o_pick_vld = |i_elig;
        o_pick_idx = '0;
        o_pick_oh  = '0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            if (w_cand_hit[k]) begin
                o_pick_idx = w_cand_idx[k];
                o_pick_oh  = w_cand_oh[k];
            end
        end
    end

endmodule

// File: rtl/tc_pl_bus_tx_sched.sv
// Round-robin scheduler of CH_NUM tx buffers onto the single PL bus transmit
// engine: grant, trigger, wait for completion or watchdog, inter-frame gap.
module tc_pl_bus_tx_sched
    import tc_pl_bus_pkg::*;
#(
    parameter int CH_NUM  = 4,
    parameter int CH_W    = 2,
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = DEF_TMO_CYC,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_NUM-1:0] ch_req,
    input  logic [CH_NUM-1:0] ch_en,
    output logic [CH_NUM-1:0] ch_gnt,
    output logic [CH_W-1:0]   ch_sel,
    output logic [CH_NUM-1:0] ch_done,
    output logic [CH_NUM-1:0] ch_err,
    output logic              busy,
    output logic              tx_trig,
    input  logic              tx_ting,
    input  logic              tx_cmpt
);

    localparam int GAP_W = (clog2(GAP_CYC + 1) < 1) ? 1 : clog2(GAP_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC == 0) ? '0 : GAP_W'(GAP_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = (TMO_CYC == 0) ? '0 : TMO_W'(TMO_CYC - 1);

    if (longint'(TMO_CYC) >= (longint'(1) << TMO_W)) begin : g_bad_tmo
        $error("TMO_CYC does not fit in TMO_W bits");
    end
    if (clog2(CH_NUM) > CH_W) begin : g_bad_chw
        $error("CH_W too narrow for CH_NUM");
    end

    state_t            r_state;
    state_t            w_state_next;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_NUM-1:0] r_gnt;
    logic [CH_W-1:0]   r_sel;
    logic [CH_NUM-1:0] r_done;
    logic [CH_NUM-1:0] r_err;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;

    logic              w_pick_vld;
    logic [CH_W-1:0]   w_pick_idx;
    logic [CH_NUM-1:0] w_pick_oh;
    logic              w_tmo_hit;
    logic              w_gap_last;
    logic              w_frame_end;
    logic              w_unused;

    // Engine status is informational only; sequencing relies on tx_cmpt.
    assign w_unused = tx_ting;

    tc_pl_bus_rr_pick #(
        .CH_NUM (CH_NUM),
        .CH_W   (CH_W)
    ) u_pick (
        .i_elig     (ch_req & ch_en),
        .i_rr_ptr   (r_rr_ptr),
        .o_pick_vld (w_pick_vld),
        .o_pick_idx (w_pick_idx),
        .o_pick_oh  (w_pick_oh)
    );

    assign w_tmo_hit   = (TMO_CYC != 0) && (r_tmo_cnt == TMO_LAST);
    assign w_gap_last  = (r_gap_cnt == GAP_LAST);
    assign w_frame_end = tx_cmpt || w_tmo_hit;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_pick_vld)  w_state_next = ST_TRIG;
            ST_TRIG:                  w_state_next = ST_WAIT;
            ST_WAIT: if (w_frame_end) w_state_next = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:  if (w_gap_last)  w_state_next = ST_IDLE;
            default:                  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != ST_IDLE);
        tx_trig = (r_state == ST_TRIG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= CH_W'(CH_NUM - 1);
            r_gnt     <= '0;
            r_sel     <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_tmo_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_gnt    <= w_pick_oh;
                        r_sel    <= w_pick_idx;
                        r_rr_ptr <= w_pick_idx;
                    end
                end
                ST_TRIG: r_tmo_cnt <= '0;
                ST_WAIT: begin
                    if (r_tmo_cnt != '1) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    // Completion takes priority over a coincident watchdog expiry.
                    if (tx_cmpt)        r_done <= r_gnt;
                    else if (w_tmo_hit) r_err  <= r_gnt;
                end
                ST_GAP: r_gap_cnt <= w_gap_last ? '0 : r_gap_cnt + GAP_W'(1);
                default: ;
            endcase
            if (r_state != ST_IDLE && w_state_next == ST_IDLE) begin
                r_gnt <= '0;
                r_sel <= '0;
            end
        end
    end

    assign ch_gnt  = r_gnt;
    assign ch_sel  = r_sel;
    assign ch_done = r_done;
    assign ch_err  = r_err;

endmodule
